alu32_sched: RTL and testbench
==============================

# alu32_sched

Round-robin scheduler that shares one registered 32-bit ALU (`alu32`) among `NREQ` requesters. Each requester presents an operand pair and a 4-bit select code under a valid/ready handshake. The scheduler issues one operation at a time to the ALU, captures the registered result and returns it with the requester index under a second valid/ready handshake. Illegal select codes are rejected without touching the ALU.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `IDW`, 2: requester index width, clog2(`NREQ`)

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  `NREQ`  per-requester operation pending
- `req_ready`  out  `NREQ`  per-requester accept; at most one bit high (one-hot or zero)
- `req_a`  in  `NREQ`*32  operand a, requester i at bits [32i+31:32i]
- `req_b`  in  `NREQ`*32  operand b, same packing
- `req_sel`  in  `NREQ`*4  select code, requester i at [4i+3:4i]
- `alu_a`, `alu_b`  out  32  registered operands to `alu32`
- `alu_sel`  out  4  registered select to `alu32`
- `alu_out`  in  32  `alu32` registered result
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer accepts response
- `rsp_id`  out  `IDW`  index of the requester that owns the response
- `rsp_data`  out  32  result
- `rsp_err`  out  1  select code was illegal; `rsp_data` is 0

## Operation
- Legal select codes are 0 AND, 1 OR, 2 XOR, 3 ADD (32-bit wrap, carry dropped). Codes 4..15 are illegal.
- FSM states are IDLE, EXEC, CAPT and RESP.
- IDLE:
  - The arbiter picks winner g among the set `req_valid` bits, starting from priority pointer `ptr` and searching upward with wrap.
  - `req_ready[g]` is driven combinationally high in IDLE only.
  - When the handshake completes at the edge, the scheduler latches `rsp_id`<=g and sets `ptr`<=(g+1) mod `NREQ`.
  - Legal select: latch `alu_a`/`alu_b`/`alu_sel` from requester g, then go to EXEC.
  - Illegal select: `rsp_data`<=0, `rsp_err`<=1, `rsp_valid`<=1, then go to RESP. ALU registers are unchanged.
- EXEC: `alu32` samples `alu_*` at this edge. Go to CAPT.
- CAPT: `rsp_data`<=`alu_out`, `rsp_err`<=0, `rsp_valid`<=1. Go to RESP.
- RESP: hold `rsp_valid`, `rsp_id`, `rsp_data` and `rsp_err` stable until `rsp_ready`. On the handshake edge, `rsp_valid`<=0 and go to IDLE.
- `alu_a`, `alu_b` and `alu_sel` hold their last issued value outside IDLE-accept edges.
- No requester is starved: after requester i is granted, every other requester with valid held high is granted within `NREQ`-1 further grants.

## Timing
- Reset values: state IDLE, `ptr` 0, `req_ready` 0 during the reset cycle, `alu_a`/`alu_b` 0, `alu_sel` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `rsp_err` 0.
- Legal op accepted at edge k:
  - `alu_*` valid after edge k.
  - ALU result after k+1.
  - `rsp_valid` high after k+2.
  - Earliest response handshake at edge k+2's following edge. With `rsp_ready` held high, that gives minimum issue spacing of 4 cycles.
- Illegal op accepted at edge k: `rsp_valid` high after edge k. Minimum spacing is 2 cycles.
- `req_ready` is 0 in EXEC, CAPT and RESP. A `req_valid` that drops while not granted is legal and is simply not selected.
- `rsp_ready` high outside RESP is ignored.
- If `rst` is asserted in any state, on that edge the in-flight operation is discarded, no response is produced, and all registers take their reset values.
- Single requester with continuous valid is granted every IDLE visit. The pointer still advances and wraps, and the grant is unaffected.

## Structure
- Package `alu32_pkg` holds:
  - select constants `SEL_AND`=4'd0, `SEL_OR`=4'd1, `SEL_XOR`=4'd2, `SEL_ADD`=4'd3
  - function `sel_legal` (true when sel[3:2]==0)
  - FSM state typedef `sched_state_t`
- Sub-module `rr_arbiter` (params `NREQ`, `IDW`):
  - inputs `req` vector, `ptr` and `advance`
  - outputs one-hot grant and encoded index
  - owns the `ptr` register, which advances on `advance`
- Top instantiates `rr_arbiter` and the FSM. `alu32` is instantiated by the integrator, not inside this block.

## Test plan
- Reset, then requester 1 sends a=0x0000_00F0, b=0x0000_0FF0, sel=0 → response after 3 cycles with `rsp_id`=1, `rsp_data`=0x0000_00F0, `rsp_err`=0.
- Requester 2 sends ADD a=0xFFFF_FFFF, b=0x0000_0002 → `rsp_data`=0x0000_0001 (wrap).
- All 4 requesters hold valid from reset → grant order 0,1,2,3,0, with issue spacing exactly 4 cycles when `rsp_ready`=1.
- Requester 3 sends sel=4'd9 → `rsp_err`=1, `rsp_data`=0 one cycle after accept, and `alu_*` unchanged.
- XOR a=0xAAAA_AAAA, b=0xFFFF_FFFF with `rsp_ready` low for 5 cycles → `rsp_data`=0x5555_5555 held stable and `req_ready` all 0 throughout.
- `rst` pulsed in CAPT → no response appears, next grant goes to requester 0, and all outputs read their reset values.

Source files
------------

// File: rtl/alu32_pkg.sv
// alu32_pkg: shared definitions for the alu32 scheduler block.
//   - ALU select codes understood by alu32
//   - sel_legal(): true for the four codes alu32 implements
//   - sched_state_t: scheduler FSM state encoding
package alu32_pkg;

  localparam logic [3:0] SEL_AND = 4'd0;
  localparam logic [3:0] SEL_OR  = 4'd1;
  localparam logic [3:0] SEL_XOR = 4'd2;
  localparam logic [3:0] SEL_ADD = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } sched_state_t;

  // Codes 0..3 are implemented; anything with a bit set in [3:2] is illegal.
  function automatic logic sel_legal(input logic [3:0] sel);
    return (sel[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/alu32_sched_if.sv
// alu32_sched_if: bus between the requesters/consumer, the scheduler and alu32.
//   req_*  : NREQ requester lanes (operands packed 32 bits per lane, sel 4 bits)
//   alu_*  : registered operands/select to alu32 and its registered result
//   rsp_*  : single response channel carrying the owning requester index
// Handshakes (req and rsp): a transfer happens on a rising edge where valid and
// ready are both high. The source holds valid and its payload stable until that
// edge; ready may depend combinationally on valid, never the other way round.
// modport master = requester/consumer/alu32 side, modport slave = scheduler.
interface alu32_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*4-1:0]  req_sel;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [3:0]         alu_sel;
  logic [31:0]        alu_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready, alu_out,
    input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready, alu_out,
    output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu32_sched_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with its own priority pointer.
//   clk, rst   : clock, synchronous active-high reset
//   req        : request vector
//   advance    : grant is being taken this cycle; pointer moves past the winner
//   grant      : one-hot winner (zero when no request)
//   grant_idx  : encoded winner
//   ptr        : current priority pointer (search starts here, wraps upward)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic [IDW-1:0]  ptr
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;
  logic [IDW:0]   nxt;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    // Walk ptr, ptr+1, ... modulo NREQ; first requester seen wins.
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      cand = sum[IDW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    nxt   = {1'b0, grant_idx} + 1'b1;
    if (nxt == NREQ_W) nxt = '0;
    if (advance && found) ptr_d = nxt[IDW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/alu32_sched.sv
// alu32_sched: shares one registered 32-bit ALU among NREQ requesters.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : alu32_sched_if slave (requests, alu32 operands/result, response)
//   dbg_state : current FSM state
//   dbg_ptr   : round-robin priority pointer
// One operation in flight at a time: IDLE accepts, EXEC lets alu32 sample its
// operands, CAPT stores the result, RESP holds it until the consumer takes it.
// Illegal select codes skip the ALU and go straight to RESP with rsp_err set.
module alu32_sched
  import alu32_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  alu32_sched_if.slave   bus,
  output sched_state_t   dbg_state,
  output logic [IDW-1:0] dbg_ptr
);

  sched_state_t    state_q, state_d;
  logic [31:0]     alu_a_q, alu_a_d;
  logic [31:0]     alu_b_q, alu_b_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            advance;
  logic [NREQ-1:0] req_ready;
  logic [3:0]      sel_g;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr       (dbg_ptr)
  );

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    advance     = 1'b0;
    req_ready   = '0;
    sel_g       = bus.req_sel[{grant_idx, 2'b00} +: 4];

    case (state_q)
      ST_IDLE: begin
        // The granted lane is ready, so any pending request is accepted now.
        if (|bus.req_valid) begin
          req_ready = rst ? '0 : grant;
          advance   = 1'b1;
          rsp_id_d  = grant_idx;
          if (sel_legal(sel_g)) begin
            alu_a_d   = bus.req_a[{grant_idx, 5'b00000} +: 32];
            alu_b_d   = bus.req_b[{grant_idx, 5'b00000} +: 32];
            alu_sel_d = sel_g;
            state_d   = ST_EXEC;
          end else begin
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_EXEC: state_d = ST_CAPT;  // alu32 registers alu_* on this edge
      ST_CAPT: begin
        rsp_data_d  = bus.alu_out;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu32_sched.sv
// tb_alu32_sched: directed bench for alu32_sched with NREQ=4.
// Contains a registered alu32 stand-in, a transaction/latency model of the
// scheduler checked every cycle, and a response scoreboard fed with
// hand-computed results.
module tb_alu32_sched;
  import alu32_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + 33;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  sched_state_t dbg_state;
  logic [1:0]   dbg_ptr;
  bit           chk_en = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  logic [W-1:0] exp_q[$];

  alu32_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu32_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel);
    case (sel)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return a + b;
      default: return 32'h0;
    endcase
  endfunction

  // Registered alu32 stand-in.
  always @(posedge clk) bus.alu_out <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);

  // ---------------- scheduler model ----------------
  // One op at a time: a legal op produces its response two edges after accept,
  // an illegal one on the accept edge itself; responses wait for rsp_ready.
  logic [1:0]  m_ptr = '0;
  bit          m_rsp_valid = 1'b0;
  int          m_wait = 0;
  logic [1:0]  m_rsp_id = '0;
  logic [31:0] m_rsp_data = '0;
  bit          m_rsp_err = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_alu_a = '0;
  logic [31:0] m_alu_b = '0;
  logic [3:0]  m_alu_sel = '0;

  function automatic int rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] c;
    for (int k = 0; k < NREQ; k++) begin
      c = 2'((int'(p) + k) % NREQ);
      if (v[c]) return int'(c);
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    g = rr_pick(bus.req_valid, m_ptr);
    if (rst || m_rsp_valid || m_wait != 0 || g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  always @(posedge clk) begin
    int         g;
    logic [1:0] gi;
    logic [3:0] sel;
    if (rst) begin
      m_ptr = '0; m_rsp_valid = 1'b0; m_wait = 0; m_rsp_id = '0; m_rsp_data = '0;
      m_rsp_err = 1'b0; m_alu_a = '0; m_alu_b = '0; m_alu_sel = '0;
    end else if (m_rsp_valid) begin
      if (bus.rsp_ready) m_rsp_valid = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_rsp_valid = 1'b1; m_rsp_data = m_result; m_rsp_err = 1'b0;
      end
    end else begin
      g = rr_pick(bus.req_valid, m_ptr);
      if (g >= 0) begin
        gi       = 2'(g);
        sel      = bus.req_sel[{gi, 2'b00} +: 4];
        m_rsp_id = gi;
        m_ptr    = 2'((g + 1) % NREQ);
        if (sel < 4'd4) begin
          m_alu_a   = bus.req_a[{gi, 5'b00000} +: 32];
          m_alu_b   = bus.req_b[{gi, 5'b00000} +: 32];
          m_alu_sel = sel;
          m_result  = alu_ref(m_alu_a, m_alu_b, sel);
          m_wait    = 2;
        end else begin
          m_rsp_valid = 1'b1; m_rsp_data = '0; m_rsp_err = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(bus.req_ready), 32'(model_ready()));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
      check("rsp_id",    32'(bus.rsp_id),    32'(m_rsp_id));
      check("rsp_data",  bus.rsp_data,       m_rsp_data);
      check("rsp_err",   32'(bus.rsp_err),   32'(m_rsp_err));
      check("alu_a",     bus.alu_a,          m_alu_a);
      check("alu_b",     bus.alu_b,          m_alu_b);
      check("alu_sel",   32'(bus.alu_sel),   32'(m_alu_sel));
    end
  end

  // Scoreboard: each response handshake pops one hand-computed expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (chk_en && !rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_id",   32'(bus.rsp_id),  32'(e[W-1:33]));
        check("sb_data", bus.rsp_data,     e[32:1]);
        check("sb_err",  32'(bus.rsp_err), 32'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel);
    bus.req_a[{id, 5'b00000} +: 32] = a;
    bus.req_b[{id, 5'b00000} +: 32] = b;
    bus.req_sel[{id, 2'b00} +: 4]   = sel;
  endtask

  // Raise valid for lane id and hold it until accepted; returns #1 after the
  // accept edge with valid dropped.
  task automatic issue(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] sel);
    bit granted;
    granted = 1'b0;
    set_op(id, a, b, sel);
    bus.req_valid[id] = 1'b1;
    for (int t = 0; t < 64 && !granted; t++) begin
      @(negedge clk);
      if (bus.req_ready[id]) granted = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("grant_seen", 32'(granted), 32'd1);
    @(posedge clk);
    #1 bus.req_valid[id] = 1'b0;
  endtask

  // Count edges from accept until rsp_valid, and pin the model's data.
  task automatic wait_rsp(input int exp_lat, input logic [31:0] exp_data);
    int lat;
    lat = 0;
    while (!bus.rsp_valid && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("model_data", m_rsp_data, exp_data);
  endtask

  task automatic finish_rsp();
    int t;
    t = 0;
    while (bus.rsp_valid && t < 64) begin
      @(posedge clk); #1;
      t++;
    end
    check("rsp_drained", 32'(bus.rsp_valid), 32'd0);
  endtask

  function automatic logic [W-1:0] pack(input logic [1:0] id, input logic [31:0] d,
                                        input logic err);
    return {id, d, err};
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int         gid[5];
    int         gcyc[5];
    int         ng;
    logic [1:0] oh_idx;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b1;

    // Reset with requester 1 already pending: no grant during reset.
    set_op(2'd1, 32'h0000_00F0, 32'h0000_0FF0, 4'd0);
    bus.req_valid[1] = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_ptr", 32'(dbg_ptr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // AND from requester 1.
    exp_q.push_back(pack(2'd1, 32'h0000_00F0, 1'b0));
    issue(2'd1, 32'h0000_00F0, 32'h0000_0FF0, 4'd0);
    wait_rsp(2, 32'h0000_00F0);
    finish_rsp();

    // ADD with 32-bit wrap from requester 2.
    exp_q.push_back(pack(2'd2, 32'h0000_0001, 1'b0));
    issue(2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 4'd3);
    wait_rsp(2, 32'h0000_0001);
    finish_rsp();

    // All four requesters valid from reset: order 0,1,2,3,0 at 4-cycle spacing.
    for (int i = 0; i < NREQ; i++) set_op(2'(i), 32'h10 * (i + 1), 32'h100, 4'd3);
    exp_q.push_back(pack(2'd0, 32'h110, 1'b0));
    exp_q.push_back(pack(2'd1, 32'h120, 1'b0));
    exp_q.push_back(pack(2'd2, 32'h130, 1'b0));
    exp_q.push_back(pack(2'd3, 32'h140, 1'b0));
    exp_q.push_back(pack(2'd0, 32'h110, 1'b0));
    bus.req_valid = 4'hF;
    do_reset();
    ng = 0;
    for (int t = 0; t < 60 && ng < 5; t++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        oh_idx = 2'd0;
        for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) oh_idx = 2'(k);
        gid[ng]  = int'(oh_idx);
        gcyc[ng] = cyc;
        ng++;
      end
      @(posedge clk);
      #1;
      if (ng == 5) bus.req_valid = '0;
    end
    check("rr_grants", 32'(ng), 32'd5);
    for (int k = 0; k < 5; k++) check("rr_order", 32'(gid[k]), 32'(k % NREQ));
    for (int k = 1; k < 5; k++) check("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd4);
    wait_rsp(2, 32'h110);
    finish_rsp();

    // Illegal select from requester 3: immediate error, ALU regs untouched.
    exp_q.push_back(pack(2'd3, 32'h0, 1'b1));
    issue(2'd3, 32'hDEAD_BEEF, 32'h0000_0001, 4'd9);
    wait_rsp(0, 32'h0);
    check("illegal_err", 32'(bus.rsp_err), 32'd1);
    check("illegal_alu_a", bus.alu_a, 32'h10);
    check("illegal_alu_b", bus.alu_b, 32'h100);
    check("illegal_alu_sel", 32'(bus.alu_sel), 32'd3);
    finish_rsp();

    // XOR with consumer stalled 5 cycles while another requester waits.
    exp_q.push_back(pack(2'd0, 32'h5555_5555, 1'b0));
    bus.rsp_ready = 1'b0;
    issue(2'd0, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 4'd2);
    wait_rsp(2, 32'h5555_5555);
    set_op(2'd1, 32'h1, 32'h2, 4'd3);
    bus.req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_data", bus.rsp_data, 32'h5555_5555);
      check("stall_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.req_valid[1] = 1'b0;
    bus.rsp_ready = 1'b1;
    finish_rsp();

    // Reset during CAPT: op discarded, everything back to reset values.
    issue(2'd2, 32'h5, 32'h6, 4'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("capt_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_rst_id", 32'(bus.rsp_id), 32'd0);
    check("post_rst_data", bus.rsp_data, 32'd0);
    check("post_rst_err", 32'(bus.rsp_err), 32'd0);
    check("post_rst_alu_a", bus.alu_a, 32'd0);
    check("post_rst_alu_b", bus.alu_b, 32'd0);
    check("post_rst_alu_sel", 32'(bus.alu_sel), 32'd0);
    check("post_rst_ptr", 32'(dbg_ptr), 32'd0);
    exp_q.push_back(pack(2'd0, 32'h000F_000F, 1'b0));
    exp_q.push_back(pack(2'd3, 32'h1234_5678, 1'b0));
    set_op(2'd0, 32'h0F0F_0F0F, 32'h00FF_00FF, 4'd0);
    set_op(2'd3, 32'h1234_0000, 32'h0000_5678, 4'd1);
    bus.req_valid = 4'b1001;
    @(negedge clk);
    check("post_rst_grant", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    wait_rsp(2, 32'h000F_000F);
    finish_rsp();
    issue(2'd3, 32'h1234_0000, 32'h0000_5678, 4'd1);
    wait_rsp(2, 32'h1234_5678);
    finish_rsp();

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
